hard_reset_phy_tx: RTL and testbench
====================================

# hard_reset_phy_tx

- Transmit-side PHY stage that sits directly downstream of the hard/cable reset transmission controller.
- On `phy_request` it serialises a USB-PD reset signal onto the line:
  - 64-bit preamble, then the 4-symbol 4b5b ordered set: Hard Reset = RST-1,RST-1,RST-1,RST-2; Cable Reset = RST-1,Sync-1,RST-1,Sync-3.
- Pulses `phy_response` when the last bit has been sent; the controller uses that pulse to report success.
- Bit pacing comes from an external `bit_tick` strobe, so the block holds no baud-rate logic.

## Interface
Parameters:
- PREAMBLE_BITS, 64, preamble length in bits; must be even and ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- phy_request  in  1  level request from the controller; held high for the whole transmission.
- transmit_type  in  3  3'b101 = Hard Reset, 3'b110 = Cable Reset; sampled only when a request is accepted.
- bit_tick  in  1  one-cycle strobe per bit time (per half-bit when HR_PHY_BMC_EN is defined).
- tx_en  out  1  line driver enable.
- tx_data  out  1  line data.
- phy_response  out  1  one-cycle completion pulse.
- tx_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, PREAMBLE, ORDSET, DONE.
- IDLE
  - `phy_request`=1 and `transmit_type` ∈ {101,110`}` → latch type, clear counters, go to PREAMBLE.
  - Any other `transmit_type` is ignored: stay in IDLE, no response. The upstream timer then reports failure.
- PREAMBLE
  - Alternating bits starting with 0, ending with 1.
  - The counter advances on each `bit_tick`.
  - After PREAMBLE_BITS bits → ORDSET.
- ORDSET
  - 4 symbols × 5 bits, each symbol sent LSB first.
  - Symbol codes: RST-1=5'b00111, RST-2=5'b11001, Sync-1=5'b11000, Sync-3=5'b00110.
  - The tick that ends bit 20 → DONE.
- DONE
  - Assert `phy_response` for exactly one cycle on entry; `tx_en`=0.
  - Stay in DONE until `phy_request`=0, then go to IDLE. This prevents retransmission on the same request.
- Abort: `phy_request`=0 in PREAMBLE or ORDSET → IDLE next cycle, `tx_en`=0, no `phy_response`.
- Reset at any time → IDLE next edge, transmission lost.
- Reset values: `tx_en`=0, `tx_data`=0, `phy_response`=0, `tx_busy`=0.
- Counters:
  - Bit counter is 7 bits, counting 0..PREAMBLE_BITS-1, then 0..19.
  - Symbol index is 2 bits and never wraps beyond 3.

## Timing
- Request accepted on edge N → `tx_en`=1 and `tx_data`=first preamble bit from N+1.
- Each bit is held from the tick that starts it until the next `bit_tick`. The first bit ends on the first tick after N+1.
- `bit_tick` is ignored in IDLE and DONE.
- `phy_response` is high the cycle after the final tick; `tx_en` falls in that same cycle.
- Total line time: (PREAMBLE_BITS+20) ticks, or 2× that with BMC.
- `bit_tick` coinciding with an abort or reset: the abort or reset wins.

## Configuration
- Macro: HR_PHY_BMC_EN.
- Defined:
  - `tx_data` is BMC-encoded and `bit_tick` is a half-bit strobe.
  - Line level toggles at every bit start, and again at mid-bit for a 1.
  - Line level register resets to 0 and is reloaded to 0 at each request acceptance.
- Undefined: `tx_data` is plain NRZ, one bit per tick, and the half-bit phase flop is absent.

## Structure
- Shared package holds:
  - transmit type codes (3'b101, 3'b110);
  - K-code constants RST-1, RST-2, Sync-1, Sync-3;
  - FSM state encoding;
  - function returning the 5-bit symbol for (type, index).
- One sub-module: `bmc_encoder`, which takes an NRZ bit and a half-bit strobe and drives the line level.
  - Instantiated only under HR_PHY_BMC_EN.

## Test plan
- Hard Reset, NRZ, `bit_tick` every 4 clocks:
  - 84 bits captured = 32×(0,1) then 11100 11100 11100 10011.
  - `phy_response` high exactly 1 cycle, after tick 84.
- Cable Reset: ordered set on line = 11100 00011 11100 01100; `tx_busy` high from request+1 until DONE exits.
- `transmit_type`=3'b001 with `phy_request` high for 500 cycles → `tx_en` stays 0, no `phy_response`.
- `phy_request` dropped at preamble bit 30 → `tx_en`=0 next cycle, no response; a new request restarts at preamble bit 0.
- `reset` asserted during ORDSET symbol 2 → all outputs 0 next edge; `phy_request` held high afterwards → full fresh transmission.
- HR_PHY_BMC_EN defined: Hard Reset decodes back to the same 84 bits, with one line transition per half-bit pair for 0 and two for 1.

Source files
------------

// File: rtl/hard_reset_phy_tx_pkg.sv
// Shared definitions for the hard/cable reset PHY transmitter: transmit type
// codes, 4b5b K-code constants, FSM state encoding and the ordered-set lookup.
package hard_reset_phy_tx_pkg;

    localparam logic [2:0] TT_HARD_RESET  = 3'b101;
    localparam logic [2:0] TT_CABLE_RESET = 3'b110;

    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC3 = 5'b00110;

    localparam int ORDSET_BITS = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ORDSET,
        ST_DONE
    } state_t;

    // True for the two transmit types this PHY knows how to send.
    function automatic logic is_reset_type(input logic [2:0] ttype);
        return (ttype == TT_HARD_RESET) || (ttype == TT_CABLE_RESET);
    endfunction

    // 5-bit K-code for symbol position idx of the ordered set of ttype.
    function automatic logic [4:0] ordset_symbol(input logic [2:0] ttype,
                                                 input logic [1:0] idx);
        logic [4:0] sym;
        sym = K_RST1;
        if (ttype == TT_CABLE_RESET) begin
            case (idx)
                2'd1:    sym = K_SYNC1;
                2'd3:    sym = K_SYNC3;
                default: sym = K_RST1;
            endcase
        end else if (idx == 2'd3) begin
            sym = K_RST2;
        end
        return sym;
    endfunction

endpackage

// File: rtl/hard_reset_phy_tx_bmc_encoder.sv
// Biphase-mark encoder: one strobe per half-bit; the line toggles at every bit
// boundary and additionally at mid-bit when the NRZ bit is 1.
module bmc_encoder
    import hard_reset_phy_tx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,         // start of a new transmission: line back to 0
    input  logic half_tick,    // end of the current half-bit
    input  logic second_half,  // half_tick closes the second half of a bit
    input  logic nrz_bit,
    output logic line_level
);

    logic level_reg;

    // Toggle at a bit boundary always, at mid-bit only for a 1.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            level_reg <= 1'b0;
        end else if (half_tick) begin
            level_reg <= level_reg ^ (second_half | nrz_bit);
        end
    end

    assign line_level = level_reg;

endmodule

// File: rtl/hard_reset_phy_tx.sv
// Hard/Cable Reset PHY transmit stage: preamble plus 4-symbol ordered set,
// paced by an external bit_tick. Optional macro HR_PHY_BMC_EN selects
// BMC line coding with bit_tick as a half-bit strobe.
module hard_reset_phy_tx
    import hard_reset_phy_tx_pkg::*;
#(
    parameter int PREAMBLE_BITS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phy_request,
    input  logic [2:0] transmit_type,
    input  logic       bit_tick,
    output logic       tx_en,
    output logic       tx_data,
    output logic       phy_response,
    output logic       tx_busy
);

    localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_BITS - 1);
    localparam logic [6:0] ORD_LAST = 7'(ORDSET_BITS - 1);

    state_t     state_reg, state_next;
    logic [6:0] bit_cnt_reg, bit_cnt_next;
    logic [1:0] sym_idx_reg, sym_idx_next;
    logic [2:0] type_reg, type_next;
    logic       resp_reg, resp_next;

    logic       active;
    logic       step;       // one full bit time has elapsed
    logic [6:0] sym_base;
    logic [2:0] bit_pos;    // bit position inside the current symbol
    logic [4:0] sym_code;
    logic       nrz_bit;

    assign active   = (state_reg == ST_PREAMBLE) || (state_reg == ST_ORDSET);
    assign sym_base = {3'b000, sym_idx_reg, 2'b00} + {5'b00000, sym_idx_reg};
    assign bit_pos  = 3'(bit_cnt_reg - sym_base);
    assign sym_code = ordset_symbol(type_reg, sym_idx_reg);

    // NRZ bit currently on the line; preamble alternates starting with 0.
    always_comb begin
        nrz_bit = 1'b0;
        if (state_reg == ST_PREAMBLE) begin
            nrz_bit = bit_cnt_reg[0];
        end else if (state_reg == ST_ORDSET) begin
            nrz_bit = sym_code[bit_pos];
        end
    end

`ifdef HR_PHY_BMC_EN
    logic phase_reg;
    logic accept;
    logic half_tick;
    logic line_level;

    assign accept    = (state_reg == ST_IDLE) && phy_request && is_reset_type(transmit_type);
    assign half_tick = active && phy_request && bit_tick;
    assign step      = bit_tick && phase_reg;

    // Half-bit phase: 0 while the first half of a bit is on the line.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            phase_reg <= 1'b0;
        end else if (half_tick) begin
            phase_reg <= ~phase_reg;
        end
    end

    bmc_encoder u_bmc (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .half_tick  (half_tick),
        .second_half(phase_reg),
        .nrz_bit    (nrz_bit),
        .line_level (line_level)
    );

    assign tx_data = active && line_level;
`else
    assign step    = bit_tick;
    assign tx_data = nrz_bit;
`endif

    // State, counters, latched type and the registered completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            sym_idx_reg <= '0;
            type_reg    <= '0;
            resp_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            sym_idx_reg <= sym_idx_next;
            type_reg    <= type_next;
            resp_reg    <= resp_next;
        end
    end

    // Next-state logic; a dropped request always beats a coincident tick.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        sym_idx_next = sym_idx_reg;
        type_next    = type_reg;
        resp_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (phy_request && is_reset_type(transmit_type)) begin
                    state_next   = ST_PREAMBLE;
                    bit_cnt_next = '0;
                    sym_idx_next = '0;
                    type_next    = transmit_type;
                end
            end
            ST_PREAMBLE: begin
                if (!phy_request) begin
                    state_next = ST_IDLE;
                end else if (step) begin
                    if (bit_cnt_reg == PRE_LAST) begin
                        state_next   = ST_ORDSET;
                        bit_cnt_next = '0;
                        sym_idx_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 7'd1;
                    end
                end
            end
            ST_ORDSET: begin
                if (!phy_request) begin
                    state_next = ST_IDLE;
                end else if (step) begin
                    if (bit_cnt_reg == ORD_LAST) begin
                        state_next = ST_DONE;
                        resp_next  = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 7'd1;
                        if (bit_pos == 3'd4) begin
                            sym_idx_next = sym_idx_reg + 2'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Hold here until the request is released so one request
                // never produces a second transmission.
                if (!phy_request) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_en        = active;
    assign tx_busy      = (state_reg != ST_IDLE);
    assign phy_response = resp_reg;

endmodule

// File: tb/tb_hard_reset_phy_tx.sv
// Self-checking bench for hard_reset_phy_tx (NRZ or BMC per HR_PHY_BMC_EN).
module tb_hard_reset_phy_tx;

    localparam int PB    = 64;
    localparam int TOTAL = PB + 20;
`ifdef HR_PHY_BMC_EN
    localparam int HALVES = 2;
`else
    localparam int HALVES = 1;
`endif

    logic       clk;
    logic       rst;
    logic       req;
    logic [2:0] ttype;
    logic       tick;
    logic       tx_en;
    logic       tx_data;
    logic       phy_response;
    logic       tx_busy;

    int checks;
    int passed;
    int txn;

    logic [4:0] hr_set [4] = '{5'b00111, 5'b00111, 5'b00111, 5'b11001};
    logic [4:0] cr_set [4] = '{5'b00111, 5'b11000, 5'b00111, 5'b00110};

    hard_reset_phy_tx #(.PREAMBLE_BITS(PB)) dut (
        .clk          (clk),
        .reset        (rst),
        .phy_request  (req),
        .transmit_type(ttype),
        .bit_tick     (tick),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .phy_response (phy_response),
        .tx_busy      (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i of the line sequence for a given transmit type.
    function automatic logic model_bit(input logic [2:0] t, input int i);
        logic [4:0] code;
        int k;
        int p;
        if (i < PB) return (i % 2) != 0;
        k = (i - PB) / 5;
        p = (i - PB) % 5;
        code = (t == 3'b101) ? hr_set[k] : cr_set[k];
        return code[p];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One request; stop_bit >= 0 interrupts it at that bit (abort or reset).
    task automatic do_tx(input logic [2:0] t, input int gmin, input int gmax,
                         input int stop_bit, input bit use_reset);
        logic lvl [2];
        logic prev;
        logic bitv;
        int   resp_cnt;
        int   en_low;
        int   trans;
        txn++;
        req = 1'b1; ttype = t; tick = 1'b0;
        cyc();
        check("start_en", tx_en, 1);
        check("start_busy", tx_busy, 1);
        check("start_data", tx_data, 0);
        resp_cnt = 0; en_low = 0; prev = 1'b0;
        for (int b = 0; b < TOTAL; b++) begin
            if (b == stop_bit) begin
                if (use_reset) rst = 1'b1;
                else req = 1'b0;
                tick = 1'b1;
                cyc();
                tick = 1'b0; rst = 1'b0;
                check("stop_en", tx_en, 0);
                check("stop_data", tx_data, 0);
                check("stop_busy", tx_busy, 0);
                check("stop_resp", phy_response, 0);
                if (!use_reset) begin
                    repeat (6) begin
                        tick = 1'($urandom_range(0, 1));
                        cyc();
                        resp_cnt += int'(phy_response);
                        en_low += int'(tx_en);
                    end
                    tick = 1'b0;
                    check("abort_quiet", resp_cnt + en_low, 0);
                end
                $display("txn %0d type=%b interrupted at bit %0d by %s", txn, t, b,
                         use_reset ? "reset" : "abort");
                return;
            end
            for (int h = 0; h < HALVES; h++) begin
                repeat ($urandom_range(gmin, gmax)) begin
                    cyc();
                    resp_cnt += int'(phy_response);
                end
                tick = 1'b1;
                lvl[h] = tx_data;
                resp_cnt += int'(phy_response);
                if (!tx_en) en_low++;
                cyc();
                tick = 1'b0;
            end
`ifdef HR_PHY_BMC_EN
            bitv = lvl[0] ^ lvl[1];
            if (b > 0) begin
                trans = int'(prev != lvl[0]) + int'(lvl[0] != lvl[1]);
                check("bmc_transitions", trans, model_bit(t, b) ? 2 : 1);
            end
            prev = lvl[1];
`else
            bitv = lvl[0];
`endif
            check("line_bit", bitv, model_bit(t, b));
        end
        check("early_resp", resp_cnt, 0);
        check("en_during_tx_low", en_low, 0);
        check("resp_pulse", phy_response, 1);
        check("end_en", tx_en, 0);
        cyc();
        check("resp_one_cycle", phy_response, 0);
        check("done_busy", tx_busy, 1);
        resp_cnt = 0; en_low = 0;
        repeat (20) begin
            tick = 1'($urandom_range(0, 1));
            cyc();
            resp_cnt += int'(phy_response);
            en_low += int'(tx_en);
            if (!tx_busy) en_low++;
        end
        tick = 1'b0;
        check("done_hold", resp_cnt + en_low, 0);
        req = 1'b0;
        cyc();
        check("release_busy", tx_busy, 0);
        $display("txn %0d type=%b completed %0d bits", txn, t, TOTAL);
    endtask

    initial begin
        int cnt;
        logic [2:0] rt;
        checks = 0; passed = 0; txn = 0;
        rst = 1'b1; req = 1'b0; ttype = 3'b000; tick = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        check("rst_en", tx_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_resp", phy_response, 0);
        check("rst_busy", tx_busy, 0);

        // Hard Reset with a tick every 4 clocks, then Cable Reset with jitter.
        do_tx(3'b101, 3, 3, -1, 1'b0);
        do_tx(3'b110, 0, 3, -1, 1'b0);

        // Unsupported transmit type is ignored.
        txn++;
        req = 1'b1; ttype = 3'b001; cnt = 0;
        repeat (500) begin
            tick = 1'($urandom_range(0, 1));
            cyc();
            cnt += int'(tx_en) + int'(phy_response) + int'(tx_busy);
        end
        req = 1'b0; tick = 1'b0;
        cyc();
        check("bad_type_quiet", cnt, 0);
        $display("txn %0d type=001 ignored for 500 cycles", txn);

        // Abort at preamble bit 30, then a fresh request starts from bit 0.
        do_tx(3'b101, 0, 2, 30, 1'b0);
        do_tx(3'b101, 0, 2, -1, 1'b0);

        // Reset during ordered-set symbol 2 with the request still held.
        do_tx(3'b110, 0, 2, PB + 12, 1'b1);
        do_tx(3'b110, 0, 2, -1, 1'b0);

        // Random types and tick spacing.
        repeat (4) begin
            rt = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110;
            do_tx(rt, 0, $urandom_range(0, 4), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
